// File: rtl/gate_output_trigger.sv
// gate_output_trigger
//   Turns changes of an upstream gate result into a fixed-length trigger pulse,
//   issuing at most one pulse per logic frame. Further changes inside the same
//   frame are dropped and counted.
//
// Ports
//   clk             single clock, rising edge
//   logic_reset     synchronous active-high reset
//   frame_start     one-cycle strobe marking a new logic frame (releases the lock)
//   in              gate result from the upstream gate
//   out             OUTPUT_COUNT identical trigger pulses, registered
//   fired           high while locked for the current frame (PULSE or LOCKED)
//   suppressed_cnt  saturating count of changes dropped because of the lock
module gate_output_trigger #(
  parameter int OUTPUT_COUNT = 2,
  parameter int PULSE_CYCLES = 1,
  parameter int SUPP_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    logic_reset,
  input  logic                    frame_start,
  input  logic                    in,
  output logic [OUTPUT_COUNT-1:0] out,
  output logic                    fired,
  output logic [SUPP_WIDTH-1:0]   suppressed_cnt
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                  state_reg;
  logic                    prev_q_reg;
  logic                    clear_pend_reg;
  logic                    pulse_reg;
  logic                    fired_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [SUPP_WIDTH-1:0]   supp_reg;

  logic change;
  logic supp_sat;

  assign change   = (in != prev_q_reg);
  assign supp_sat = &supp_reg;

  always_ff @(posedge clk) begin
    if (logic_reset) begin
      state_reg      <= IDLE;
      prev_q_reg     <= 1'b0;
      clear_pend_reg <= 1'b0;
      pulse_reg      <= 1'b0;
      fired_reg      <= 1'b0;
      cnt_reg        <= '0;
      supp_reg       <= '0;
    end else begin
      prev_q_reg <= in;
      case (state_reg)
        IDLE: begin
          // frame_start alone is meaningless here: nothing is locked.
          if (change) begin
            state_reg <= PULSE;
            cnt_reg   <= PULSE_LOAD;
            pulse_reg <= 1'b1;
            fired_reg <= 1'b1;
          end
        end

        PULSE: begin
          // The pulse always runs its full length; any change during it is
          // dropped, and a frame_start is only remembered for the exit.
          if (change && !supp_sat) begin
            supp_reg <= supp_reg + 1'b1;
          end
          if (cnt_reg == CNT_ONE) begin
            pulse_reg      <= 1'b0;
            cnt_reg        <= '0;
            clear_pend_reg <= 1'b0;
            if (clear_pend_reg || frame_start) begin
              state_reg <= IDLE;
              fired_reg <= 1'b0;
            end else begin
              state_reg <= LOCKED;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            if (frame_start) begin
              clear_pend_reg <= 1'b1;
            end
          end
        end

        LOCKED: begin
          if (frame_start) begin
            // New frame: a change arriving with the strobe belongs to the new
            // frame and fires immediately instead of being dropped.
            if (change) begin
              state_reg <= PULSE;
              cnt_reg   <= PULSE_LOAD;
              pulse_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              fired_reg <= 1'b0;
            end
          end else if (change && !supp_sat) begin
            supp_reg <= supp_reg + 1'b1;
          end
        end

        default: begin
          state_reg      <= IDLE;
          pulse_reg      <= 1'b0;
          fired_reg      <= 1'b0;
          cnt_reg        <= '0;
          clear_pend_reg <= 1'b0;
        end
      endcase
    end
  end

  // Every downstream wire carries the same registered pulse.
  generate
    for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_out
      assign out[gi] = pulse_reg;
    end
  endgenerate

  assign fired          = fired_reg;
  assign suppressed_cnt = supp_reg;

endmodule
